// File: rtl/lms_pkg.sv
// Shared widths, saturation limits and FSM encoding for the LMS error/update block.
package lms_pkg;
   localparam int DATA_W   = 16;
   localparam int SUM_W    = 32;
   localparam int FRAC_DEF = 15;
   localparam int SAT_MAX  = 32767;
   localparam int SAT_MIN  = -32768;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ERR  = 2'd1,
      ST_MUL  = 2'd2,
      ST_HOLD = 2'd3
   } lms_state_t;
endpackage

// File: rtl/lms_sat_round.sv
// Optional round-half-up, arithmetic right shift by SHIFT, then saturate to DATA_W signed.
module lms_sat_round
   import lms_pkg::*;
#(
   parameter int IN_W  = 32,
   parameter int SHIFT = FRAC_DEF,
   parameter bit ROUND = 1'b1
) (
   input  logic signed [IN_W-1:0]   din,
   output logic signed [DATA_W-1:0] dout,
   output logic                     sat
);
   // One guard bit so the rounding add can never wrap.
   localparam int SW  = IN_W + 1;
   localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [SW-1:0] RND_C = (ROUND && (SHIFT > 0)) ?
                                     ({{(SW-1){1'b0}}, 1'b1} << RSH) : {SW{1'b0}};
   localparam logic signed [SW-1:0] MAX_V = SW'(SAT_MAX);
   localparam logic signed [SW-1:0] MIN_V = SW'(SAT_MIN);

   logic signed [SW-1:0] ext;
   logic signed [SW-1:0] rnd;
   logic signed [SW-1:0] shf;

   always_comb begin
      ext  = {din[IN_W-1], din};
      rnd  = ext + $signed(RND_C);
      shf  = rnd >>> SHIFT;
      sat  = 1'b0;
      dout = shf[DATA_W-1:0];
      if (shf > MAX_V) begin
         dout = DATA_W'(SAT_MAX);
         sat  = 1'b1;
      end else if (shf < MIN_V) begin
         dout = DATA_W'(SAT_MIN);
         sat  = 1'b1;
      end
   end
endmodule

// File: rtl/lms_err_update.sv
// LMS error and mu*e update stage with handshake to the tap chain.
// Define LMS_ERR_ENERGY_EN to build the windowed error-energy accumulator.
//
// state   | meaning
// IDLE    | in_ready=1, waiting for a desired/sum_in pair
// ERR     | e = desired - y, saturated, registered to err_out
// MUL     | mu*e rounded/saturated, registered to upd_out, upd_valid set
// HOLD    | outputs frozen until upd_ready, then tap_enable pulse
module lms_err_update
   import lms_pkg::*;
#(
   parameter int TAPS = 8,
   parameter int FRAC = FRAC_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] desired,
   input  logic signed [SUM_W-1:0]  sum_in,
   input  logic signed [DATA_W-1:0] step_size,
   output logic signed [DATA_W-1:0] err_out,
   output logic signed [DATA_W-1:0] upd_out,
   output logic                     upd_valid,
   input  logic                     upd_ready,
   output logic                     tap_enable,
   output logic                     sat_flag,
   output logic [31:0]              err_energy,
   output logic                     energy_valid
);
   if (TAPS < 2 || TAPS > 256 || (TAPS & (TAPS - 1)) != 0) begin : g_taps_bad
      $error("TAPS must be a power of two in 2..256");
   end

   lms_state_t               state;
   logic signed [DATA_W-1:0] desired_r;
   logic signed [SUM_W-1:0]  sum_r;
   logic signed [DATA_W-1:0] step_r;
   logic                     sat_err;

   logic signed [SUM_W-1:0]  y_sh;
   logic signed [SUM_W:0]    e_wide;
   logic signed [DATA_W-1:0] e_sat;
   logic                     e_sat_hit;
   logic signed [SUM_W-1:0]  prod;
   logic signed [DATA_W-1:0] u_sat;
   logic                     u_sat_hit;

   assign y_sh   = sum_r >>> FRAC;
   assign e_wide = {{(SUM_W+1-DATA_W){desired_r[DATA_W-1]}}, desired_r} - {y_sh[SUM_W-1], y_sh};
   // Both factors are 16-bit, so the 32-bit product is exact.
   assign prod   = {{(SUM_W-DATA_W){step_r[DATA_W-1]}}, step_r} *
                   {{(SUM_W-DATA_W){err_out[DATA_W-1]}}, err_out};

   lms_sat_round #(.IN_W(SUM_W+1), .SHIFT(0), .ROUND(1'b0)) u_err_sat (
      .din  (e_wide),
      .dout (e_sat),
      .sat  (e_sat_hit)
   );

   lms_sat_round #(.IN_W(SUM_W), .SHIFT(FRAC), .ROUND(1'b1)) u_mul_sat (
      .din  (prod),
      .dout (u_sat),
      .sat  (u_sat_hit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         in_ready   <= 1'b1;
         desired_r  <= '0;
         sum_r      <= '0;
         step_r     <= '0;
         sat_err    <= 1'b0;
         err_out    <= '0;
         upd_out    <= '0;
         upd_valid  <= 1'b0;
         tap_enable <= 1'b0;
         sat_flag   <= 1'b0;
      end else begin
         tap_enable <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_valid && in_ready) begin
                  desired_r <= desired;
                  sum_r     <= sum_in;
                  step_r    <= step_size;
                  in_ready  <= 1'b0;
                  state     <= ST_ERR;
               end
            end
            ST_ERR: begin
               err_out <= e_sat;
               sat_err <= e_sat_hit;
               state   <= ST_MUL;
            end
            ST_MUL: begin
               upd_out   <= u_sat;
               upd_valid <= 1'b1;
               sat_flag  <= sat_err | u_sat_hit;
               state     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (upd_ready) begin
                  upd_valid  <= 1'b0;
                  sat_flag   <= 1'b0;
                  tap_enable <= 1'b1;
                  in_ready   <= 1'b1;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef LMS_ERR_ENERGY_EN
   localparam int CW = $clog2(TAPS);

   logic [CW-1:0] win_cnt;
   logic [31:0]   acc;
   logic [31:0]   e_sq;
   logic [32:0]   sum_wide;
   logic [31:0]   acc_next;

   assign e_sq     = {{(32-DATA_W){e_sat[DATA_W-1]}}, e_sat} *
                     {{(32-DATA_W){e_sat[DATA_W-1]}}, e_sat};
   assign sum_wide = {1'b0, acc} + {1'b0, e_sq};
   assign acc_next = sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];

   // One sample enters the window per ERR cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_cnt      <= '0;
         acc          <= '0;
         err_energy   <= '0;
         energy_valid <= 1'b0;
      end else begin
         energy_valid <= 1'b0;
         if (state == ST_ERR) begin
            if (win_cnt == CW'(TAPS - 1)) begin
               err_energy   <= acc_next;
               energy_valid <= 1'b1;
               acc          <= '0;
               win_cnt      <= '0;
            end else begin
               acc     <= acc_next;
               win_cnt <= win_cnt + CW'(1);
            end
         end
      end
   end
`else
   assign err_energy   = '0;
   assign energy_valid = 1'b0;
`endif
endmodule

// File: tb/tb_lms_err_update.sv
// Self-checking bench: transaction-level reference model plus directed literal vectors.
module tb_lms_err_update;
   localparam int TAPS = 8;
   localparam int FRAC = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        upd_ready = 1'b1;
   logic [15:0] desired = '0;
   logic [31:0] sum_in = '0;
   logic [15:0] step_size = '0;
   logic        in_ready;
   logic [15:0] err_out;
   logic [15:0] upd_out;
   logic        upd_valid;
   logic        tap_enable;
   logic        sat_flag;
   logic [31:0] err_energy;
   logic        energy_valid;

   int n_tests = 0;
   int n_fail  = 0;

   lms_err_update #(.TAPS(TAPS), .FRAC(FRAC)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .desired      (desired),
      .sum_in       (sum_in),
      .step_size    (step_size),
      .err_out      (err_out),
      .upd_out      (upd_out),
      .upd_valid    (upd_valid),
      .upd_ready    (upd_ready),
      .tap_enable   (tap_enable),
      .sat_flag     (sat_flag),
      .err_energy   (err_energy),
      .energy_valid (energy_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: dut=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: plain integer maths on the sample values.
   function automatic void model_calc(input longint d, input longint s, input longint mu,
                                      output longint e, output longint u, output bit sat);
      longint p;
      sat = 1'b0;
      e = d - (s >>> FRAC);
      if (e > 32767) begin e = 32767; sat = 1'b1; end
      else if (e < -32768) begin e = -32768; sat = 1'b1; end
      p = mu * e;
      u = (p + (longint'(1) << (FRAC - 1))) >>> FRAC;
      if (u > 32767) begin u = 32767; sat = 1'b1; end
      else if (u < -32768) begin u = -32768; sat = 1'b1; end
   endfunction

   longint m_e, m_u;
   bit     m_s;
   bit     busy = 1'b0;
   int     age = 0;
   longint exp_err = 0, exp_upd = 0, exp_energy = 0;
   bit     exp_rdy = 1'b1, exp_uv = 1'b0, exp_tap = 1'b0, exp_sat = 1'b0, exp_ev = 1'b0;
   longint acc = 0;
   int     wcnt = 0;

   task automatic model_reset();
      busy = 0; age = 0;
      exp_err = 0; exp_upd = 0; exp_energy = 0;
      exp_rdy = 1; exp_uv = 0; exp_tap = 0; exp_sat = 0; exp_ev = 0;
      acc = 0; wcnt = 0;
   endtask

   // Timeline model: error one edge after accept, update two edges after, then wait for upd_ready.
   task automatic model_step();
      exp_tap = 0;
      exp_ev  = 0;
      if (busy) begin
         age++;
         if (age == 1) begin
            exp_err = m_e;
`ifdef LMS_ERR_ENERGY_EN
            acc += m_e * m_e;
            wcnt++;
            if (wcnt == TAPS) begin
               exp_energy = (acc > 64'd4294967295) ? 64'd4294967295 : acc;
               exp_ev = 1;
               acc = 0;
               wcnt = 0;
            end
`endif
         end else if (age == 2) begin
            exp_upd = m_u;
            exp_uv  = 1;
            exp_sat = m_s;
         end else if (exp_uv && upd_ready) begin
            exp_uv  = 0;
            exp_sat = 0;
            exp_tap = 1;
            busy    = 0;
            exp_rdy = 1;
         end
      end else if (in_valid) begin
         model_calc(longint'($signed(desired)), longint'($signed(sum_in)),
                    longint'($signed(step_size)), m_e, m_u, m_s);
         busy = 1;
         age = 0;
         exp_rdy = 0;
      end
   endtask

   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
   end

   initial forever begin
      @(negedge clk);
      chk("in_ready",     in_ready,                    exp_rdy);
      chk("err_out",      longint'($signed(err_out)),  exp_err);
      chk("upd_out",      longint'($signed(upd_out)),  exp_upd);
      chk("upd_valid",    upd_valid,                   exp_uv);
      chk("tap_enable",   tap_enable,                  exp_tap);
      chk("sat_flag",     sat_flag,                    exp_sat);
      chk("err_energy",   longint'(err_energy),        exp_energy);
      chk("energy_valid", energy_valid,                exp_ev);
   end

   task automatic send(input logic [15:0] d, input logic [31:0] s, input logic [15:0] mu);
      int n;
      n = 0;
      @(negedge clk);
      desired = d; sum_in = s; step_size = mu; in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("accept_wait_in_ready", in_ready, 1);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
   endtask

   task automatic run_vec(input logic [15:0] d, input logic [31:0] s, input logic [15:0] mu,
                          input longint ee, input longint eu, input longint es);
      send(d, s, mu);
      @(negedge clk);
      chk("lit_uv_edge1", upd_valid, 0);
      @(negedge clk);
      chk("lit_err", longint'($signed(err_out)), ee);
      chk("lit_uv_edge1b", upd_valid, 0);
      @(negedge clk);
      chk("lit_upd", longint'($signed(upd_out)), eu);
      chk("lit_uv_edge2", upd_valid, 1);
      chk("lit_sat", sat_flag, es);
      @(negedge clk);
      chk("lit_tap_pulse", tap_enable, 1);
      @(negedge clk);
      chk("lit_tap_single", tap_enable, 0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
   endtask

   initial begin
      longint v;
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_upd_valid", upd_valid, 0);
      chk("rst_err_out", longint'($signed(err_out)), 0);
      #2 reset = 1'b1;

      run_vec(16'd1000, 32'd16384000, 16'd16384, 500, 250, 0);
      run_vec(16'sd32767, -32'sd1073741824, 16'sd32767, 32767, 32766, 1);
      run_vec(-16'sd32768, 32'sd1073709056, -16'sd32768, -32768, 32767, 1);
      run_vec(16'd1234, 32'd0, 16'd0, 1234, 0, 0);

      // Backpressure: hold upd_ready low, then release with a new pair already offered.
      upd_ready = 1'b0;
      send(16'd1000, 32'd16384000, 16'd16384);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         chk("hold_uv", upd_valid, 1);
         chk("hold_upd", longint'($signed(upd_out)), 250);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_tap", tap_enable, 0);
         @(negedge clk);
      end
      upd_ready = 1'b1;
      desired = 16'd100; sum_in = 32'd0; step_size = 16'd16384; in_valid = 1'b1;
      @(negedge clk);
      chk("hs_tap", tap_enable, 1);
      chk("hs_in_ready", in_ready, 1);
      chk("hs_uv", upd_valid, 0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("hs_tap_single", tap_enable, 0);
      @(negedge clk);
      chk("hs_next_err", longint'($signed(err_out)), 100);
      @(negedge clk);
      chk("hs_next_upd", longint'($signed(upd_out)), 50);
      repeat (3) @(negedge clk);

      // Reset while the sample is in MUL.
      send(16'd1000, 32'd16384000, 16'd16384);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("rmul_in_ready", in_ready, 1);
      chk("rmul_err", longint'($signed(err_out)), 0);
      chk("rmul_upd", longint'($signed(upd_out)), 0);
      chk("rmul_uv", upd_valid, 0);
      chk("rmul_tap", tap_enable, 0);
      chk("rmul_sat", sat_flag, 0);
      chk("rmul_energy", longint'(err_energy), 0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      run_vec(16'd1000, 32'd16384000, 16'd16384, 500, 250, 0);

      // Randomized traffic checked by the model.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 2) != 0);
         upd_ready = ($urandom_range(0, 3) != 0);
         desired   = 16'($urandom);
         case ($urandom_range(0, 4))
            0: step_size = 16'd0;
            1: step_size = 16'h8000;
            2: step_size = 16'h7FFF;
            default: step_size = 16'($urandom);
         endcase
         case ($urandom_range(0, 2))
            0: sum_in = $urandom;
            1: begin
               v = longint'($signed(desired)) * 32768 + longint'($urandom_range(0, 2000000)) - 1000000;
               sum_in = v[31:0];
            end
            default: sum_in = 32'($urandom_range(0, 1 << 20));
         endcase
      end
      @(negedge clk);
      in_valid = 1'b0;
      upd_ready = 1'b1;
      repeat (6) @(negedge clk);

`ifdef LMS_ERR_ENERGY_EN
      pulse_reset();
      for (int k = 0; k < TAPS; k++) send(16'd256, 32'd0, 16'd16384);
      @(negedge clk);
      @(negedge clk);
      chk("energy_value", longint'(err_energy), 524288);
      chk("energy_pulse", energy_valid, 1);
      @(negedge clk);
      chk("energy_single", energy_valid, 0);
      repeat (4) @(negedge clk);
`else
      pulse_reset();
      repeat (4) @(negedge clk);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end
endmodule
